serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder built around one instance of the existing 1-bit full_adder cell.
- A carry flip-flop closes the loop around the cell, so sum and carry-out come from one cell over WIDTH clock cycles.
- Sits directly downstream of the full_adder cell, consuming its sum/c_out each cycle; used where area matters more than latency.
- Parallel operands in via a valid/ready handshake; parallel result out via a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- in_valid  input  1  operands a/b/cin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A; sampled only on accept.
- b  input  WIDTH  operand B; sampled only on accept.
- cin  input  1  carry-in; sampled only on accept.
- out_valid  output  1  sum/c_out hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result bits (a+b+cin) mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous) has the following effects:
  - state=IDLE.
  - Shift registers, sum register, carry flop and bit counter all go to 0.
  - in_ready=1 after reset releases; out_valid=0, sum=0, c_out=0.
- States: IDLE, SHIFT, DONE. Encoding is one-hot internally.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0; go to SHIFT.
  - in_valid low: stay in IDLE.
- SHIFT:
  - in_ready=0; out_valid=0.
  - Each cycle the full_adder sees a_sr[0], b_sr[0] and carry.
  - Register updates per cycle:
    - Its sum bit shifts into sum_sr MSB; sum_sr shifts right.
    - a_sr and b_sr shift right.
    - carry<=cell c_out; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, that final bit completes; go to DONE.
- DONE:
  - out_valid=1; sum=sum_sr; c_out=carry. Both held stable until out_ready is sampled high.
  - On out_valid && out_ready: go to IDLE. out_valid drops next cycle.
- Latency:
  - Accepted at edge k, out_valid is high after edge k+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (DONE plus IDLE bubble).
- Boundary rules:
  - in_valid during SHIFT/DONE is ignored; no state change and no capture. Upstream must hold in_valid.
  - Operand changes after accept have no effect on the result in flight.
  - out_ready high in DONE does not permit a same-cycle new accept; in_ready stays 0 until IDLE.
  - out_ready is ignored outside DONE.
  - Overflow wraps modulo 2^WIDTH; the lost bit appears only on c_out.
  - rst_n asserted mid-SHIFT or in DONE aborts the operation immediately. No partial result is ever presented and out_valid goes 0 asynchronously.
- Counter width is clog2(WIDTH); cnt never exceeds WIDTH-1.
- sum/c_out read 0 in IDLE/SHIFT; they carry meaning only while out_valid=1.

Decomposition:
- Shared package serial_adder_pkg holds the state encoding constants (ST_IDLE, ST_SHIFT, ST_DONE) and the counter-width function/constant.
- One sub-module: existing full_adder (ports a, b, cin, sum, c_out), instantiated once as the datapath cell.
- Control FSM, shift registers and carry flop live in serial_adder itself.

Test Plan (WIDTH=8):
- Reset then idle: rst_n low 3 cycles then high -> in_ready=1, out_valid=0, sum=0x00, c_out=0.
- Basic: a=0x7F, b=0x01, cin=0 -> out_valid exactly 8 cycles after accept, sum=0x80, c_out=0.
- Carry chain:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, c_out=1.
  - a=0xA5, b=0x5A, cin=1 -> sum=0x00, c_out=1.
- Backpressure and ignored input:
  - out_ready held low 5 cycles in DONE -> sum/c_out/out_valid stable throughout; retire on first out_ready high.
  - in_valid with a=0x11 during SHIFT -> not captured, result unaffected.
- Reset mid-operation: assert rst_n low at 3rd SHIFT cycle of a=0xF0, b=0x0F -> out_valid=0 immediately. After release, a=0x03, b=0x04, cin=1 -> sum=0x08, c_out=0.
- Random 1000 back-to-back transactions with random out_ready -> every result equals {c_out,sum}=a+b+cin; initiation interval never below 10 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and
// counter sizing.
package serial_adder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_SHIFT = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

    // At least one bit so the counter stays a legal vector.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell, the datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ cin;
    assign c_out = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder cell with a carry flop,
// operands and result exchanged over valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (1'b1)
                state[0]: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                state[1]: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    // Clear on the last bit so cnt never passes WIDTH-1.
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                state[2]: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the one-hot state flops.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign sum       = out_valid ? sum_sr : '0;
    assign c_out     = out_valid & carry;

endmodule
